cpu_core_dump_master: RTL and testbench

- AXI4-Lite initiator that drives the CPU core controller's register-snapshot slave from the fabric side.
- On a START pulse it reads all 32 general registers and the PC, one transaction at a time, and presents each word on a strobed output port.
- It also issues single host-requested AXI-Lite writes, for example to the controller's core-reset control word.
- It sits between the debug/host logic and the controller's S_AXI port.

---
 rtl/cpu_core_dump_master.sv | 233 +++++++++++++++++++++++
 tb/tb_cpu_core_dump_master.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_dump_master.sv
// AXI4-Lite initiator for the CPU core controller: dumps REG00..REG31 and the PC
// word by word on START, and performs single host-requested writes on WR_REQ.
module cpu_core_dump_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 16,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = 16'h0000,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] PC_OFFSET = 16'h0080,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                              CCLK,
    input  logic                              CRST,
    input  logic                              START,
    input  logic                              WR_REQ,
    input  logic [15:0]                       WR_ADDR,
    input  logic [31:0]                       WR_DATA,
    output logic                              BUSY,
    output logic                              DUMP_VALID,
    output logic [5:0]                        DUMP_IDX,
    output logic [31:0]                       DUMP_DATA,
    output logic                              DONE,
    output logic                              ERR,
    output logic                              TIMEOUT,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned WD_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B} state_t;

    state_t                          r_state;
    logic [5:0]                      r_idx;
    logic [AW-1:0]                   r_araddr;
    logic                            r_arvalid;
    logic                            r_rready;
    logic [AW-1:0]                   r_awaddr;
    logic                            r_awvalid;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
    logic                            r_wvalid;
    logic                            r_bready;
    logic                            r_busy;
    logic                            r_dumpValid;
    logic [5:0]                      r_dumpIdx;
    logic [31:0]                     r_dumpData;
    logic                            r_done;
    logic                            r_err;
    logic                            r_timeout;
    logic [31:0]                     r_wdog;

    logic                            w_arHs;
    logic                            w_rHs;
    logic                            w_awHs;
    logic                            w_wHs;
    logic                            w_bHs;
    logic                            w_awDone;
    logic                            w_wDone;
    logic                            w_lastWord;
    logic                            w_waiting;
    logic                            w_wdFire;
    logic [5:0]                      w_nextIdx;
    logic [AW-1:0]                   w_nextAddr;

    assign w_arHs     = r_arvalid & m_axi_arready;
    assign w_rHs      = r_rready & m_axi_rvalid;
    assign w_awHs     = r_awvalid & m_axi_awready;
    assign w_wHs      = r_wvalid & m_axi_wready;
    assign w_bHs      = r_bready & m_axi_bvalid;
    assign w_awDone   = ~r_awvalid | m_axi_awready;
    assign w_wDone    = ~r_wvalid | m_axi_wready;
    assign w_lastWord = (r_idx == 6'd32);
    assign w_nextIdx  = r_idx + 6'd1;
    assign w_nextAddr = (w_nextIdx == 6'd32) ? PC_OFFSET
                                             : BASE_ADDR + AW'({w_nextIdx[4:0], 2'b00});
    assign w_wdFire   = (TIMEOUT_CYCLES != 0) && (r_wdog == WD_LAST);

    // A state is "waiting" on any cycle in which none of its handshakes complete.
    always_comb begin
        w_waiting = 1'b0;
        case (r_state)
            RD_AR:   w_waiting = ~w_arHs;
            RD_R:    w_waiting = ~w_rHs;
            WR_AWW:  w_waiting = ~(w_awHs | w_wHs);
            WR_B:    w_waiting = ~w_bHs;
            default: w_waiting = 1'b0;
        endcase
    end

    always_ff @(posedge CCLK or posedge CRST) begin
        if (CRST) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_busy      <= 1'b0;
            r_dumpValid <= 1'b0;
            r_dumpIdx   <= '0;
            r_dumpData  <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_timeout   <= 1'b0;
            r_wdog      <= '0;
        end else begin
            r_dumpValid <= 1'b0;
            r_done      <= 1'b0;
            if (w_waiting && w_wdFire) begin
                // Hung slave: abandon the transaction even mid-handshake.
                r_arvalid <= 1'b0;
                r_rready  <= 1'b0;
                r_awvalid <= 1'b0;
                r_wvalid  <= 1'b0;
                r_bready  <= 1'b0;
                r_err     <= 1'b1;
                r_timeout <= 1'b1;
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
                r_wdog    <= '0;
                r_state   <= IDLE;
            end else begin
                r_wdog <= w_waiting ? r_wdog + 32'd1 : 32'd0;
                case (r_state)
                    IDLE: begin
                        if (START) begin
                            r_busy    <= 1'b1;
                            r_err     <= 1'b0;
                            r_timeout <= 1'b0;
                            r_idx     <= '0;
                            r_araddr  <= BASE_ADDR;
                            r_arvalid <= 1'b1;
                            r_state   <= RD_AR;
                        end else if (WR_REQ) begin
                            r_busy    <= 1'b1;
                            r_err     <= 1'b0;
                            r_timeout <= 1'b0;
                            r_awaddr  <= AW'(WR_ADDR);
                            r_wdata   <= WR_DATA;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR_AWW;
                        end
                    end
                    RD_AR: begin
                        if (w_arHs) begin
                            r_arvalid <= 1'b0;
                            r_rready  <= 1'b1;
                            r_state   <= RD_R;
                        end
                    end
                    RD_R: begin
                        if (w_rHs) begin
                            r_rready    <= 1'b0;
                            r_dumpValid <= 1'b1;
                            r_dumpIdx   <= r_idx;
                            r_dumpData  <= m_axi_rdata;
                            if (m_axi_rresp != 2'b00) r_err <= 1'b1;
                            if (w_lastWord) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end else begin
                                r_idx     <= w_nextIdx;
                                r_araddr  <= w_nextAddr;
                                r_arvalid <= 1'b1;
                                r_state   <= RD_AR;
                            end
                        end
                    end
                    WR_AWW: begin
                        if (w_awHs) r_awvalid <= 1'b0;
                        if (w_wHs)  r_wvalid  <= 1'b0;
                        if (w_awDone && w_wDone) begin
                            r_bready <= 1'b1;
                            r_state  <= WR_B;
                        end
                    end
                    WR_B: begin
                        if (w_bHs) begin
                            r_bready <= 1'b0;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            if (m_axi_bresp != 2'b00) r_err <= 1'b1;
                            r_state  <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign BUSY          = r_busy;
    assign DUMP_VALID    = r_dumpValid;
    assign DUMP_IDX      = r_dumpIdx;
    assign DUMP_DATA     = r_dumpData;
    assign DONE          = r_done;
    assign ERR           = r_err;
    assign TIMEOUT       = r_timeout;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;

endmodule

// File: tb/tb_cpu_core_dump_master.sv
// Bench for cpu_core_dump_master: a delay-configurable AXI-Lite slave plus a
// queue-based model of the expected dump sequence and write transactions.
`timescale 1ns/1ps
module tb_cpu_core_dump_master;

    logic        CCLK = 1'b0;
    logic        CRST, START, WR_REQ;
    logic [15:0] WR_ADDR;
    logic [31:0] WR_DATA;
    logic        BUSY, DUMP_VALID, DONE, ERR, TIMEOUT;
    logic [5:0]  DUMP_IDX;
    logic [31:0] DUMP_DATA;
    logic [15:0] m_axi_araddr, m_axi_awaddr;
    logic [2:0]  m_axi_arprot, m_axi_awprot;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_rdata, m_axi_wdata;
    logic [1:0]  m_axi_rresp, m_axi_bresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid, m_axi_bready;

    cpu_core_dump_master #(.TIMEOUT_CYCLES(16)) dut (
        .CCLK(CCLK), .CRST(CRST), .START(START), .WR_REQ(WR_REQ),
        .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .BUSY(BUSY),
        .DUMP_VALID(DUMP_VALID), .DUMP_IDX(DUMP_IDX), .DUMP_DATA(DUMP_DATA),
        .DONE(DONE), .ERR(ERR), .TIMEOUT(TIMEOUT),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    always #5 CCLK = ~CCLK;

    int checks = 0;
    int errors = 0;

    // Slave configuration
    int          arDelay = 0, rDelay = 0, awDelay = 0, wDelay = 0, bDelay = 0;
    int          errAddr = -1, hangAddr = -1, stableErr = 0;
    bit          randDelay = 0, checkStable = 0, slaveClear = 0;
    logic [31:0] dataBase = 32'h1000;
    logic [1:0]  bRespVal = 2'b00;

    // Slave internal state
    bit          rPend, arWaiting, awGot, wGot;
    int          arCnt, rCnt, awCnt, wCnt, bCnt;
    logic [15:0] rAddr, holdAddr, pAraddr, pAwaddr;
    bit          pArv, pRr, pAwv, pWv, pBr;
    logic [31:0] pWdata;
    logic [3:0]  pWstrb;

    // Observation logs
    int          strobeIdx[$];
    logic [31:0] strobeData[$];
    bit          strobeErr[$];
    logic [15:0] arLog[$], awLog[$];
    logic [31:0] wLog[$];
    logic [3:0]  wstrbLog[$];
    int          cycle = 0, doneCount = 0, doneCycle = -1, firstArCycle = -1;
    int          lastStrobeCycle = -1, rreadyRise = -1, doneNoFall = 0;
    bit          doneErr, doneTimeout, doneRready, doneBusy;
    bit          prevBusy = 0, prevArvalid = 0, prevRready = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference address map: REGn at 4*n, PC word at 0x80
    function automatic logic [15:0] modelAddr(input int i);
        return (i < 32) ? 16'(4 * i) : 16'h0080;
    endfunction

    always @(negedge CCLK) begin
        cycle++;
        if (DUMP_VALID) begin
            strobeIdx.push_back(int'(DUMP_IDX));
            strobeData.push_back(DUMP_DATA);
            strobeErr.push_back(ERR);
            lastStrobeCycle = cycle;
        end
        if (DONE) begin
            doneCount++;
            doneCycle   = cycle;
            doneErr     = ERR;
            doneTimeout = TIMEOUT;
            doneRready  = m_axi_rready;
            doneBusy    = BUSY;
            if (!(prevBusy && !BUSY)) doneNoFall++;
        end
        if (m_axi_arvalid && !prevArvalid && firstArCycle < 0) firstArCycle = cycle;
        if (m_axi_rready && !prevRready) rreadyRise = cycle;
        prevBusy    = BUSY;
        prevArvalid = m_axi_arvalid;
        prevRready  = m_axi_rready;
    end

    // Slave: readies/valids change on the falling edge, handshakes are those
    // that were set up at the previous falling edge.
    initial begin
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        forever begin
            @(negedge CCLK);
            if (CRST || slaveClear) begin
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0;
                m_axi_wready = 0; m_axi_bvalid = 0;
                rPend = 0; arWaiting = 0; awGot = 0; wGot = 0;
                arCnt = 0; rCnt = 0; awCnt = 0; wCnt = 0; bCnt = 0;
            end else begin
                if (pArv && m_axi_arready) begin
                    rPend = 1; rAddr = pAraddr; arLog.push_back(pAraddr);
                    arCnt = 0; rCnt = 0; arWaiting = 0;
                    if (randDelay) begin
                        arDelay = $urandom_range(0, 3);
                        rDelay  = $urandom_range(0, 3);
                    end
                end
                if (pRr && m_axi_rvalid) begin
                    m_axi_rvalid = 0; rPend = 0;
                end
                m_axi_arready = 0;
                if (rPend && !m_axi_rvalid && int'(rAddr) != hangAddr) begin
                    if (rCnt < rDelay) rCnt++;
                    else begin
                        m_axi_rvalid = 1;
                        m_axi_rdata  = dataBase + 32'(rAddr);
                        m_axi_rresp  = (int'(rAddr) == errAddr) ? 2'b10 : 2'b00;
                    end
                end
                if (!rPend && m_axi_arvalid) begin
                    if (checkStable && arWaiting && m_axi_araddr != holdAddr) stableErr++;
                    if (!arWaiting) begin
                        arWaiting = 1; holdAddr = m_axi_araddr;
                    end
                    if (arCnt < arDelay) arCnt++;
                    else m_axi_arready = 1;
                end else if (!rPend && checkStable && arWaiting) begin
                    stableErr++;
                end

                if (pAwv && m_axi_awready) begin
                    awGot = 1; awLog.push_back(pAwaddr); awCnt = 0;
                end
                if (pWv && m_axi_wready) begin
                    wGot = 1; wLog.push_back(pWdata); wstrbLog.push_back(pWstrb); wCnt = 0;
                end
                if (pBr && m_axi_bvalid) begin
                    m_axi_bvalid = 0; awGot = 0; wGot = 0; bCnt = 0;
                end
                m_axi_awready = 0;
                m_axi_wready  = 0;
                if (m_axi_awvalid && !awGot) begin
                    if (awCnt < awDelay) awCnt++; else m_axi_awready = 1;
                end
                if (m_axi_wvalid && !wGot) begin
                    if (wCnt < wDelay) wCnt++; else m_axi_wready = 1;
                end
                if (awGot && wGot && !m_axi_bvalid) begin
                    if (bCnt < bDelay) bCnt++;
                    else begin
                        m_axi_bvalid = 1; m_axi_bresp = bRespVal;
                    end
                end
            end
            pArv = m_axi_arvalid; pAraddr = m_axi_araddr; pRr = m_axi_rready;
            pAwv = m_axi_awvalid; pAwaddr = m_axi_awaddr;
            pWv = m_axi_wvalid; pWdata = m_axi_wdata; pWstrb = m_axi_wstrb;
            pBr = m_axi_bready;
        end
    end

    task automatic applyStimulus(input logic st, input logic wr, input logic [15:0] addr, input logic [31:0] data);
        @(negedge CCLK);
        START = st; WR_REQ = wr; WR_ADDR = addr; WR_DATA = data;
        @(negedge CCLK);
        START = 0; WR_REQ = 0;
    endtask

    task automatic clearLogs();
        strobeIdx.delete(); strobeData.delete(); strobeErr.delete();
        arLog.delete(); awLog.delete(); wLog.delete(); wstrbLog.delete();
        doneCount = 0; doneCycle = -1; firstArCycle = -1; lastStrobeCycle = -1;
    endtask

    task automatic waitDone(input int limit, input string tag);
        int n = 0;
        while (doneCount == 0 && n < limit) begin
            @(negedge CCLK);
            n++;
        end
        #1;
        checkOutput({tag, ".doneSeen"}, 64'(doneCount != 0), 1);
    endtask

    task automatic waitStrobes(input int count, input int limit, input string tag);
        int n = 0;
        while (strobeIdx.size() < count && n < limit) begin
            @(negedge CCLK);
            n++;
        end
        checkOutput({tag, ".strobesReached"}, 64'(strobeIdx.size() >= count), 1);
    endtask

    task automatic verifyDump(input string name, input int nStrobe, input int nAr,
                              input int errFrom, input logic [31:0] base);
        checkOutput({name, ".strobes"}, 64'(strobeIdx.size()), 64'(nStrobe));
        if (nAr >= 0) checkOutput({name, ".arCount"}, 64'(arLog.size()), 64'(nAr));
        for (int i = 0; i < nStrobe && i < strobeIdx.size(); i++) begin
            checkOutput($sformatf("%s.idx%0d", name, i), 64'(strobeIdx[i]), 64'(i));
            checkOutput($sformatf("%s.data%0d", name, i), strobeData[i], base + 32'(modelAddr(i)));
            checkOutput($sformatf("%s.err%0d", name, i), strobeErr[i],
                        64'(errFrom >= 0 && i >= errFrom));
        end
        for (int i = 0; i < nStrobe && i < arLog.size(); i++)
            checkOutput($sformatf("%s.araddr%0d", name, i), arLog[i], modelAddr(i));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".ctrl"},
            {BUSY, DUMP_VALID, DUMP_IDX, DONE, ERR, TIMEOUT, m_axi_arvalid, m_axi_rready,
             m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_araddr, m_axi_awaddr}, 0);
        checkOutput({tag, ".data"}, {DUMP_DATA, m_axi_wdata}, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        logic [31:0] base;
        logic [15:0] wa;
        logic [31:0] wd;
        CRST = 1; START = 0; WR_REQ = 0; WR_ADDR = 0; WR_DATA = 0;
        repeat (3) @(negedge CCLK);
        checkResetOutputs("reset");
        checkOutput("constants", {m_axi_arprot, m_axi_awprot, m_axi_wstrb}, {3'b000, 3'b000, 4'hF});
        CRST = 0;
        repeat (2) @(negedge CCLK);

        // Zero-wait dump; a simultaneous WR_REQ must be dropped
        $display("[TB] zero-wait dump");
        clearLogs();
        applyStimulus(1, 1, 16'h0200, $urandom);
        waitDone(400, "zw");
        repeat (3) @(negedge CCLK);
        verifyDump("zw", 33, 33, -1, 32'h1000);
        checkOutput("zw.doneCount", 64'(doneCount), 1);
        checkOutput("zw.doneLag", 64'(doneCycle - lastStrobeCycle), 0);
        checkOutput("zw.cycles", 64'(doneCycle - firstArCycle), 66);
        checkOutput("zw.err", doneErr, 0);
        checkOutput("zw.noWrite", 64'(awLog.size()), 0);

        // Delayed AR/R slave
        $display("[TB] delayed dump");
        clearLogs();
        base = $urandom; dataBase = base;
        arDelay = 3; rDelay = 2; checkStable = 1; stableErr = 0;
        applyStimulus(1, 0, 0, 0);
        waitDone(1000, "dly");
        repeat (2) @(negedge CCLK);
        checkStable = 0;
        verifyDump("dly", 33, 33, -1, base);
        checkOutput("dly.arStable", 64'(stableErr), 0);
        checkOutput("dly.doneCount", 64'(doneCount), 1);
        arDelay = 0; rDelay = 0;

        // Single write, awready two cycles ahead of wready
        $display("[TB] single write");
        clearLogs();
        awDelay = 0; wDelay = 2; bDelay = 1; bRespVal = 2'b00;
        applyStimulus(0, 1, 16'h0100, 32'h0000_0001);
        waitDone(100, "wr");
        repeat (3) @(negedge CCLK);
        checkOutput("wr.awCount", 64'(awLog.size()), 1);
        checkOutput("wr.awaddr", (awLog.size() > 0) ? awLog[0] : 16'hFFFF, 16'h0100);
        checkOutput("wr.wdata", (wLog.size() > 0) ? wLog[0] : 32'hFFFF_FFFF, 32'h1);
        checkOutput("wr.wstrb", (wstrbLog.size() > 0) ? wstrbLog[0] : 4'h0, 4'hF);
        checkOutput("wr.doneCount", 64'(doneCount), 1);
        checkOutput("wr.err", doneErr, 0);
        checkOutput("wr.noStrobe", 64'(strobeIdx.size()), 0);

        // Random write answered with SLVERR
        $display("[TB] random write with error response");
        clearLogs();
        wa = $urandom; wd = $urandom;
        awDelay = $urandom_range(0, 3); wDelay = $urandom_range(0, 3); bDelay = $urandom_range(0, 3);
        bRespVal = 2'b10;
        applyStimulus(0, 1, wa, wd);
        waitDone(100, "wrr");
        repeat (2) @(negedge CCLK);
        checkOutput("wrr.awaddr", (awLog.size() > 0) ? awLog[0] : ~wa, wa);
        checkOutput("wrr.wdata", (wLog.size() > 0) ? wLog[0] : ~wd, wd);
        checkOutput("wrr.err", doneErr, 1);
        bRespVal = 2'b00; awDelay = 0; wDelay = 0; bDelay = 0;

        // SLVERR on idx 5 with random per-beat delays
        $display("[TB] dump with slave error");
        clearLogs();
        base = $urandom; dataBase = base;
        errAddr = 16'h0014; randDelay = 1;
        applyStimulus(1, 0, 0, 0);
        waitDone(1000, "se");
        repeat (2) @(negedge CCLK);
        verifyDump("se", 33, 33, 5, base);
        checkOutput("se.errFinal", doneErr, 1);
        errAddr = -1; randDelay = 0; arDelay = 0; rDelay = 0;

        // R never answered on idx 3 -> watchdog
        $display("[TB] watchdog");
        clearLogs();
        base = $urandom; dataBase = base;
        hangAddr = 16'h000C;
        applyStimulus(1, 0, 0, 0);
        waitDone(200, "to");
        repeat (6) @(negedge CCLK);
        verifyDump("to", 3, 4, -1, base);
        checkOutput("to.timeout", doneTimeout, 1);
        checkOutput("to.err", doneErr, 1);
        checkOutput("to.rready", doneRready, 0);
        checkOutput("to.busy", doneBusy, 0);
        checkOutput("to.waitCycles", 64'(doneCycle - rreadyRise), 16);
        hangAddr = -1;
        slaveClear = 1;
        repeat (2) @(negedge CCLK);
        slaveClear = 0;
        clearLogs();
        applyStimulus(1, 0, 0, 0);
        #1;
        checkOutput("to.flagsCleared", {BUSY, ERR, TIMEOUT}, 3'b100);
        waitDone(400, "to2");
        repeat (2) @(negedge CCLK);
        verifyDump("to2", 33, 33, -1, base);

        // Reset mid-dump at idx 10, with a START while busy beforehand
        $display("[TB] reset mid-dump");
        clearLogs();
        base = $urandom; dataBase = base;
        applyStimulus(1, 0, 0, 0);
        waitStrobes(5, 100, "rst.a");
        applyStimulus(1, 0, 0, 0);
        waitStrobes(11, 100, "rst.b");
        CRST = 1;
        #1;
        checkResetOutputs("rst.async");
        repeat (2) @(negedge CCLK);
        CRST = 0;
        repeat (2) @(negedge CCLK);
        verifyDump("rst", 11, -1, -1, base);
        checkOutput("rst.noDone", 64'(doneCount), 0);
        checkOutput("rst.idle", {BUSY, m_axi_arvalid}, 0);
        clearLogs();
        applyStimulus(1, 0, 0, 0);
        waitDone(400, "rst2");
        repeat (2) @(negedge CCLK);
        verifyDump("rst2", 33, 33, -1, base);

        checkOutput("doneWithBusyFall", 64'(doneNoFall), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
